frame_check_sequence_engine: RTL and testbench
==============================================

FRAME_CHECK_SEQUENCE_ENGINE -- requirements
Module: frame_check_sequence_engine

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, giving bytes per beat; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the frame and error counters.
REQ-003 SHALL have port clock, input, 1: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low; clock clock.
REQ-005 SHALL have port data, input, 8*DATA_BYTES: payload; byte 0 = data[7:0] is first on the wire.
REQ-006 SHALL have port data_keep, input, DATA_BYTES: per-byte valid flags.
REQ-007 SHALL have ports data_valid (input, 1), data_last (input, 1) and data_ready (output, 1): input beat handshake.
REQ-008 SHALL have port check_mode, input, 1: 0 = generate FCS, 1 = check a frame that carries its trailing 4-byte FCS.
REQ-009 SHALL have ports fcs (output, 32), fcs_error (output, 1), fcs_valid (output, 1) and fcs_ready (input, 1): result handshake.
REQ-010 SHALL have ports frame_count and error_count, outputs, COUNT_WIDTH each: saturating statistics.

Function
REQ-011 SHALL compute IEEE 802.3 CRC-32: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, each byte processed LSB first.
REQ-012 SHALL process all kept bytes of a beat in one cycle, in order byte 0 to byte DATA_BYTES-1.
REQ-013 SHALL accept a beat only when data_valid and data_ready are both 1.
REQ-014 SHALL treat data_keep as all-ones on non-last beats.
REQ-015 SHALL, on a last beat, process only the lowest contiguous run of set keep bits; keep = 0 on a last beat closes the frame without adding bytes.
REQ-016 SHALL use state S_CALCULATE (data_ready = 1) and state S_RESULT (data_ready = 0, fcs_valid = 1).
REQ-017 SHALL move from S_CALCULATE to S_RESULT on an accepted beat with data_last = 1; fcs_valid SHALL assert the cycle after that beat is accepted.
REQ-018 SHALL move from S_RESULT to S_CALCULATE when fcs_ready = 1; data_ready SHALL return to 1 the next cycle, giving one bubble cycle.
REQ-019 SHALL hold fcs and fcs_error stable while fcs_valid = 1 and fcs_ready = 0.
REQ-020 SHALL reload the CRC register to 0xFFFFFFFF on the S_RESULT to S_CALCULATE transition.
REQ-021 SHALL, in generate mode, output fcs = ~register with fcs[7:0] as the first FCS byte transmitted; fcs_error SHALL be 0.
REQ-022 SHALL, in check mode, set fcs_error = 1 if and only if the final register (before inversion) is not 0xDEBB20E3; fcs SHALL carry ~register.
REQ-023 SHALL latch check_mode on the first accepted beat of a frame; changes to check_mode mid-frame SHALL be ignored.
REQ-024 SHALL increment frame_count on each result handshake; error_count SHALL increment on each handshake with fcs_error = 1; both SHALL saturate at all-ones.
REQ-025 SHALL ignore data_valid while in S_RESULT; no beat is consumed.

Reset
REQ-026 SHALL, on reset, set state = S_CALCULATE, CRC register = 0xFFFFFFFF, data_ready = 1, fcs_valid = 0, fcs = 0, fcs_error = 0, and both counters = 0.
REQ-027 SHALL, on reset mid-frame or mid-result, discard the partial frame and pending result with no fcs_valid pulse and no count.

Structure
REQ-028 SHALL take from a shared package frame_check_sequence_pkg: the state enum, CRC_POLYNOMIAL, CRC_INIT = 0xFFFFFFFF, and CRC_RESIDUE = 0xDEBB20E3.
REQ-029 SHALL implement the per-byte update as combinational sub-module crc32_byte_update (32-bit state in, 8-bit byte in, 32-bit state out), chained DATA_BYTES times with a keep-gated bypass per stage.

Verification
REQ-030 SHALL verify: DATA_BYTES = 4, generate mode, beats 0x34333231/F, 0x38373635/F, 0x00000039/1 last -> fcs = 0xCBF43926, fcs_error = 0, frame_count = 1.
REQ-031 SHALL verify: DATA_BYTES = 4, check mode, bytes "123456789" followed by 26 39 F4 CB -> fcs_error = 0; same frame with 0x31 changed to 0x30 -> fcs_error = 1, error_count = 1.
REQ-032 SHALL verify: DATA_BYTES = 1, single byte 0x00 with last -> fcs = 0xD202EF8D one cycle after acceptance.
REQ-033 SHALL verify: fcs_ready held 0 for 5 cycles -> fcs_valid stays 1, fcs stays stable, data_ready stays 0; fcs_ready = 1 -> data_ready = 1 the next cycle, and a back-to-back frame gives the correct independent result.
REQ-034 SHALL verify: reset_n = 0 after 2 beats of a frame, then a full "123456789" frame -> no result for the aborted frame, fcs = 0xCBF43926, frame_count = 1.
REQ-035 SHALL verify: COUNT_WIDTH = 2, 5 erroneous check-mode frames -> frame_count = 3 and error_count = 3 (saturated).

Source files
------------

// File: rtl/frame_check_sequence_pkg.sv
// Shared definitions for the IEEE 802.3 frame check sequence engine:
// FSM states and CRC-32 constants.
package frame_check_sequence_pkg;

  typedef enum logic [0:0] {
    S_CALCULATE = 1'b0,
    S_RESULT    = 1'b1
  } fcs_state_e;

  localparam logic [31:0] CRC_POLYNOMIAL = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] value);
    logic [31:0] result;
    for (int i = 0; i < 32; i++) begin
      result[i] = value[31-i];
    end
    return result;
  endfunction

  // The register shifts right, so the polynomial is applied bit-reversed.
  localparam logic [31:0] CRC_POLY_REFLECTED = reflect32(CRC_POLYNOMIAL);

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_byte_update
  import frame_check_sequence_pkg::*;
(
  input  logic [31:0] state_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] state_o
);

  logic [31:0] acc;

  always_comb begin
    acc = state_i ^ {24'h000000, byte_i};
    for (int b = 0; b < 8; b++) begin
      if (acc[0]) begin
        acc = (acc >> 1) ^ CRC_POLY_REFLECTED;
      end else begin
        acc = acc >> 1;
      end
    end
    state_o = acc;
  end

endmodule

// File: rtl/frame_check_sequence_engine.sv
// Streaming CRC-32 FCS generator/checker: DATA_BYTES bytes per beat, result
// handshake, and saturating frame/error statistics.
module frame_check_sequence_engine
  import frame_check_sequence_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   data_keep,
  input  logic                    data_valid,
  input  logic                    data_last,
  output logic                    data_ready,
  input  logic                    check_mode,
  output logic [31:0]             fcs,
  output logic                    fcs_error,
  output logic                    fcs_valid,
  input  logic                    fcs_ready,
  output logic [COUNT_WIDTH-1:0]  frame_count,
  output logic [COUNT_WIDTH-1:0]  error_count
);

  fcs_state_e             state_q, state_d;
  logic [31:0]            crc_q, crc_d;
  logic                   mode_q, mode_d;
  logic                   first_q, first_d;
  logic [31:0]            fcs_q, fcs_d;
  logic                   fcs_error_q, fcs_error_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;

  logic [DATA_BYTES-1:0]  keep_eff;
  logic                   keep_run;
  logic [31:0]            chain [DATA_BYTES+1];
  logic [31:0]            upd   [DATA_BYTES];
  logic                   beat_accept;
  logic                   mode_now;
  logic [31:0]            crc_final;

  // Non-last beats are always full; a last beat keeps only its lowest
  // contiguous run of set keep bits.
  always_comb begin
    keep_eff = '1;
    keep_run = 1'b1;
    if (data_last) begin
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
        keep_run    = keep_run & data_keep[i];
        keep_eff[i] = keep_run;
      end
    end
  end

  assign chain[0] = crc_q;

  for (genvar g = 0; g < int'(DATA_BYTES); g++) begin : g_stage
    crc32_byte_update u_update (
      .state_i (chain[g]),
      .byte_i  (data[8*g +: 8]),
      .state_o (upd[g])
    );
    assign chain[g+1] = keep_eff[g] ? upd[g] : chain[g];
  end

  assign crc_final   = chain[DATA_BYTES];
  assign data_ready  = (state_q == S_CALCULATE);
  assign fcs_valid   = (state_q == S_RESULT);
  assign beat_accept = data_valid && data_ready;
  assign mode_now    = first_q ? check_mode : mode_q;

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    mode_d        = mode_q;
    first_d       = first_q;
    fcs_d         = fcs_q;
    fcs_error_d   = fcs_error_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;

    case (state_q)
      S_CALCULATE: begin
        if (beat_accept) begin
          crc_d   = crc_final;
          mode_d  = mode_now;
          first_d = 1'b0;
          if (data_last) begin
            state_d     = S_RESULT;
            fcs_d       = ~crc_final;
            fcs_error_d = mode_now && (crc_final != CRC_RESIDUE);
          end
        end
      end
      S_RESULT: begin
        if (fcs_ready) begin
          state_d = S_CALCULATE;
          crc_d   = CRC_INIT;
          first_d = 1'b1;
          if (frame_count_q != '1) begin
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
          end
          if (fcs_error_q && (error_count_q != '1)) begin
            error_count_d = error_count_q + COUNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_CALCULATE;
        crc_d   = CRC_INIT;
        first_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_CALCULATE;
      crc_q         <= CRC_INIT;
      mode_q        <= 1'b0;
      first_q       <= 1'b1;
      fcs_q         <= 32'h0;
      fcs_error_q   <= 1'b0;
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      mode_q        <= mode_d;
      first_q       <= first_d;
      fcs_q         <= fcs_d;
      fcs_error_q   <= fcs_error_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign fcs         = fcs_q;
  assign fcs_error   = fcs_error_q;
  assign frame_count = frame_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_frame_check_sequence_engine.sv
// Directed bench: 4-byte engine, 1-byte engine and a 2-bit-counter engine.
module tb_frame_check_sequence_engine;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Shared beat inputs for the 4-byte and saturating-counter instances.
  logic [31:0] d_data;
  logic [3:0]  d_keep;
  logic        d_last;
  logic        d_mode;

  logic        v4, r4, fr4, err4, val4;
  logic [31:0] fcs4;
  logic [15:0] fc4, ec4;

  logic        vc, rc, frc, errc, valc;
  logic [31:0] fcsc;
  logic [1:0]  fcc, ecc;

  logic [7:0]  b_data;
  logic        b_keep, b_valid, b_last, b_mode, b_ready, b_fr, err1, val1;
  logic [31:0] fcs1;
  logic [15:0] fc1, ec1;

  frame_check_sequence_engine #(.DATA_BYTES(4), .COUNT_WIDTH(16)) u_dut4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .data        (d_data),
    .data_keep   (d_keep),
    .data_valid  (v4),
    .data_last   (d_last),
    .data_ready  (r4),
    .check_mode  (d_mode),
    .fcs         (fcs4),
    .fcs_error   (err4),
    .fcs_valid   (val4),
    .fcs_ready   (fr4),
    .frame_count (fc4),
    .error_count (ec4)
  );

  frame_check_sequence_engine #(.DATA_BYTES(4), .COUNT_WIDTH(2)) u_dutc (
    .clock       (clock),
    .reset_n     (reset_n),
    .data        (d_data),
    .data_keep   (d_keep),
    .data_valid  (vc),
    .data_last   (d_last),
    .data_ready  (rc),
    .check_mode  (d_mode),
    .fcs         (fcsc),
    .fcs_error   (errc),
    .fcs_valid   (valc),
    .fcs_ready   (frc),
    .frame_count (fcc),
    .error_count (ecc)
  );

  frame_check_sequence_engine #(.DATA_BYTES(1), .COUNT_WIDTH(16)) u_dut1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .data        (b_data),
    .data_keep   (b_keep),
    .data_valid  (b_valid),
    .data_last   (b_last),
    .data_ready  (b_ready),
    .check_mode  (b_mode),
    .fcs         (fcs1),
    .fcs_error   (err1),
    .fcs_valid   (val1),
    .fcs_ready   (b_fr),
    .frame_count (fc1),
    .error_count (ec1)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel 0 drives the 4-byte engine, sel 1 the saturating-counter engine.
  task automatic send_beat(input int sel, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
    int n;
    d_data = d;
    d_keep = k;
    d_last = l;
    if (sel == 0) v4 = 1'b1;
    else vc = 1'b1;
    n = 0;
    while (((sel == 0) ? !r4 : !rc) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 50) check_value("ready_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    v4 = 1'b0;
    vc = 1'b0;
    d_last = 1'b0;
  endtask

  task automatic send_line(input int sel, input logic [31:0] ef, input logic ee,
                           input logic chk_fcs, input string tag);
    int n;
    n = 0;
    while (((sel == 0) ? !val4 : !valc) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 50) check_value({tag, "_valid_timeout"}, 64'd0, 64'd1);
    if (chk_fcs) check_value({tag, "_fcs"}, (sel == 0) ? fcs4 : fcsc, ef);
    check_value({tag, "_err"}, (sel == 0) ? err4 : errc, ee);
    if (sel == 0) fr4 = 1'b1;
    else frc = 1'b1;
    @(posedge clock); #1;
    fr4 = 1'b0;
    frc = 1'b0;
    check_value({tag, "_ready_back"}, (sel == 0) ? r4 : rc, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
    int n;
    b_data  = d;
    b_keep  = k;
    b_last  = l;
    b_valid = 1'b1;
    n = 0;
    while (!b_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 50) check_value("byte_ready_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    d_data = '0; d_keep = '0; d_last = 1'b0; d_mode = 1'b0;
    v4 = 1'b0; fr4 = 1'b0; vc = 1'b0; frc = 1'b0;
    b_data = '0; b_keep = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_mode = 1'b0; b_fr = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    check_value("rst_ready", r4, 1'b1);
    check_value("rst_valid", val4, 1'b0);
    check_value("rst_fcs", fcs4, 32'h0);
    check_value("rst_err", err4, 1'b0);
    check_value("rst_fc", fc4, 16'd0);
    check_value("rst_ec", ec4, 16'd0);

    // Abort a frame with reset after two beats.
    send_beat(0, 32'h34333231, 4'hF, 1'b0);
    send_beat(0, 32'h38373635, 4'hF, 1'b0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_value("abort_valid", val4, 1'b0);
    check_value("abort_fc", fc4, 16'd0);
    check_value("abort_ready", r4, 1'b1);

    // "123456789" generate, then hold the result for 5 cycles with a beat offered.
    d_mode = 1'b0;
    send_beat(0, 32'h34333231, 4'hF, 1'b0);
    send_beat(0, 32'h38373635, 4'hF, 1'b0);
    send_beat(0, 32'h00000039, 4'h1, 1'b1);
    check_value("gen_valid_next", val4, 1'b1);
    v4 = 1'b1; d_data = 32'hFFFFFFFF; d_keep = 4'hF; d_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check_value("hold_valid", val4, 1'b1);
      check_value("hold_fcs", fcs4, 32'hCBF43926);
      check_value("hold_ready", r4, 1'b0);
    end
    v4 = 1'b0; d_last = 1'b0;
    send_line(0, 32'hCBF43926, 1'b0, 1'b1, "gen");
    check_value("gen_fc", fc4, 16'd1);

    // Back-to-back single zero byte.
    send_beat(0, 32'h00000000, 4'h1, 1'b1);
    send_line(0, 32'hD202EF8D, 1'b0, 1'b1, "b2b");
    check_value("b2b_fc", fc4, 16'd2);

    // Check mode, good frame: residue gives fcs = ~0xDEBB20E3.
    d_mode = 1'b1;
    send_beat(0, 32'h34333231, 4'hF, 1'b0);
    send_beat(0, 32'h38373635, 4'hF, 1'b0);
    send_beat(0, 32'hF4392639, 4'hF, 1'b0);
    send_beat(0, 32'h000000CB, 4'h1, 1'b1);
    send_line(0, 32'h2144DF1C, 1'b0, 1'b1, "chk_good");
    check_value("chk_good_ec", ec4, 16'd0);

    // Check mode, corrupted first byte; mode drops mid-frame and must be ignored.
    d_mode = 1'b1;
    send_beat(0, 32'h34333230, 4'hF, 1'b0);
    d_mode = 1'b0;
    send_beat(0, 32'h38373635, 4'hF, 1'b0);
    send_beat(0, 32'hF4392639, 4'hF, 1'b0);
    send_beat(0, 32'h000000CB, 4'h1, 1'b1);
    send_line(0, 32'h0, 1'b1, 1'b0, "chk_bad");
    check_value("chk_bad_ec", ec4, 16'd1);
    check_value("chk_bad_fc", fc4, 16'd4);

    // Generate; mode rises mid-frame, last keep 1101 uses only byte 0.
    d_mode = 1'b0;
    send_beat(0, 32'h34333231, 4'hF, 1'b0);
    d_mode = 1'b1;
    send_beat(0, 32'h38373635, 4'hF, 1'b0);
    send_beat(0, 32'hAA000039, 4'hD, 1'b1);
    send_line(0, 32'hCBF43926, 1'b0, 1'b1, "gen_keep");
    check_value("gen_keep_fc", fc4, 16'd5);
    check_value("gen_keep_ec", ec4, 16'd1);

    // 1-byte engine: zero byte, result visible the cycle after acceptance.
    b_mode = 1'b0;
    send_byte(8'h00, 1'b1, 1'b1);
    check_value("byte_valid_next", val1, 1'b1);
    check_value("byte_fcs", fcs1, 32'hD202EF8D);
    b_fr = 1'b1;
    @(posedge clock); #1;
    b_fr = 1'b0;
    check_value("byte_ready_back", b_ready, 1'b1);

    // 1-byte engine: "123456789" closed by a keep = 0 last beat.
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    check_value("byte_close_valid", val1, 1'b1);
    check_value("byte_close_fcs", fcs1, 32'hCBF43926);
    b_fr = 1'b1;
    @(posedge clock); #1;
    b_fr = 1'b0;
    check_value("byte_fc", fc1, 16'd2);

    // 2-bit counters saturate after 5 erroneous check frames.
    d_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat(1, 32'h00000001, 4'hF, 1'b1);
      send_line(1, 32'h0, 1'b1, 1'b0, "sat");
    end
    check_value("sat_fc", fcc, 2'd3);
    check_value("sat_ec", ecc, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
